// File: rtl/btn_debounce_if.sv
// Push-button conditioning bundle: raw pin in, debounced level and busy flag out.
interface btn_debounce_if;
    logic btn_raw;
    logic btn_clean;
    logic busy;

    modport master (
        output btn_raw,
        input  btn_clean,
        input  busy
    );

    modport slave (
        input  btn_raw,
        output btn_clean,
        output busy
    );
endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchronizer feeding a counter-qualified level FSM.
// btn_clean flips only after the synchronized pin holds its new level long enough.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic          clk,
    input  logic          rst,
    btn_debounce_if.slave bus
);
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clean;
    logic             clean_nxt;
    logic             s1;
    logic             s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= STABLE_LOW;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            s1    <= bus.btn_raw;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            clean <= clean_nxt;
        end
    end

    // Counter clears on every transition, so it never runs past LAST.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clean_nxt = clean;
        case (state)
            STABLE_LOW: begin
                clean_nxt = 1'b0;
                if (s2) begin
                    state_nxt = CHECK_HIGH;
                    cnt_nxt   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!s2) begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = STABLE_HIGH;
                    clean_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                clean_nxt = 1'b1;
                if (!s2) begin
                    state_nxt = CHECK_LOW;
                    cnt_nxt   = '0;
                end
            end
            CHECK_LOW: begin
                if (s2) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = STABLE_LOW;
                    clean_nxt = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE_LOW;
                cnt_nxt   = '0;
                clean_nxt = 1'b0;
            end
        endcase
    end

    assign bus.btn_clean = clean;
    assign bus.busy      = (state == CHECK_HIGH) || (state == CHECK_LOW);
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: run-length reference model plus directed latency pins.
module tb_btn_debounce;
    localparam int D = 4;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    btn_debounce_if bus ();

    btn_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // Model: output flips after D+1 consecutive edges on which s2 differs from it.
    bit ms1 = 1'b0;
    bit ms2 = 1'b0;
    bit mclean = 1'b0;
    int run = 0;

    // Downstream single-pulse edge FSM (registered output).
    logic bi_q = 1'b0;
    logic bo = 1'b0;
    always @(posedge clk) begin
        bi_q <= bus.btn_clean;
        bo   <= bus.btn_clean && !bi_q;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rs);
        @(negedge clk);
        bus.btn_raw = r;
        rst = rs;
        @(posedge clk);
        if (!rs) begin
            ms1 = 0; ms2 = 0; mclean = 0; run = 0;
        end else begin
            if (ms2 != mclean) begin
                run++;
                if (run == D + 1) begin
                    mclean = !mclean;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            ms2 = ms1;
            ms1 = r;
        end
        chk_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("clean", {31'd0, bus.btn_clean}, {31'd0, mclean});
            check("busy", {31'd0, bus.busy}, {31'd0, run > 0});
        end
    end

    // Hold r for n edges; report first edge index at which busy / output reach r.
    task automatic hold(input logic r, input int n,
                        output int busy_at, output int clean_at, output int m_at);
        busy_at = -1; clean_at = -1; m_at = -1;
        for (int i = 0; i < n; i++) begin
            cyc(r, 1'b1);
            if (busy_at < 0 && bus.busy === 1'b1) busy_at = i;
            if (clean_at < 0 && bus.btn_clean === r) clean_at = i;
            if (m_at < 0 && mclean == r) m_at = i;
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1);
    endtask

    int b_at, c_at, m_at, cnt_a, cnt_b;
    logic bounce [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic r;

    initial begin
        bus.btn_raw = 1'b0;
        // Reset with pin high, then release and qualify.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        check("rst_clean", {31'd0, bus.btn_clean}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        hold(1'b1, 10, b_at, c_at, m_at);
        check("t1_busy_at", b_at, 32'd2);
        check("t1_rise_at", c_at, 32'd6);
        check("t1_model_rise", m_at, 32'd6);
        settle();

        // Clean press and release.
        hold(1'b1, 20, b_at, c_at, m_at);
        check("t2_rise_at", c_at, 32'd6);
        check("t2_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("t2_held", {31'd0, bus.btn_clean}, 32'd1);
        hold(1'b0, 10, b_at, c_at, m_at);
        check("t2_fall_at", c_at, 32'd6);
        check("t2_model_fall", m_at, 32'd6);
        settle();

        // Bouncing press.
        c_at = -1;
        for (int i = 0; i < 18; i++) begin
            r = (i < 6) ? bounce[i] : 1'b1;
            cyc(r, 1'b1);
            if (c_at < 0 && bus.btn_clean === 1'b1) c_at = i;
        end
        check("t3_rise_at", c_at, 32'd11);
        settle();

        // One-cycle glitch.
        cnt_a = 0; cnt_b = 0;
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1);
            if (bus.busy === 1'b1) cnt_a++;
            if (bus.btn_clean !== 1'b0) cnt_b++;
        end
        check("t4_busy_cycles", cnt_a, 32'd1);
        check("t4_clean_stuck", cnt_b, 32'd0);

        // Reset during qualification.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        check("t5_clean", {31'd0, bus.btn_clean}, 32'd0);
        check("t5_busy", {31'd0, bus.busy}, 32'd0);
        hold(1'b1, 10, b_at, c_at, m_at);
        check("t5_rise_at", c_at, 32'd6);
        settle();

        // Chained edge FSM: one pulse, 7 edges after the press.
        b_at = -1; cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1);
            if (bo === 1'b1) begin
                cnt_a++;
                if (b_at < 0) b_at = i;
            end
        end
        check("t6_bo_at", b_at, 32'd7);
        check("t6_bo_width", cnt_a, 32'd1);
        settle();

        // Random bouncing with occasional resets.
        for (int i = 0; i < 3000; ) begin
            r = 1'($urandom_range(0, 1));
            cnt_a = $urandom_range(1, 8);
            for (int j = 0; j < cnt_a; j++) begin
                cyc(r, ($urandom_range(0, 149) != 0));
                i++;
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
